// File: rtl/arp_resolve.sv
// ARP initiator: broadcasts an ARP request for a target IPv4, matches the reply and retries on timeout.
// Optional single-entry result cache is built when ARP_CACHE_EN is defined.
module arp_resolve #(
    parameter logic [47:0] MAC_ADDR       = 48'hDEADBEEFCAFE,
    parameter logic [31:0] IP_ADDR        = 32'h69696969,
    parameter int          TIMEOUT_CYCLES = 1_250_000,
    parameter int          MAX_TRIES      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_ip,
    output logic        req_ready,
    output logic        res_valid,
    output logic [47:0] res_mac,
    output logic        res_err,
    input  logic        rx_done,
    input  logic [15:0] rx_oper,
    input  logic [47:0] rx_sha,
    input  logic [31:0] rx_spa,
    input  logic [31:0] rx_tpa,
    output logic        tx_en,
    output logic [47:0] tx_dest,
    output logic [15:0] tx_ethertype,
    input  logic        tx_send_next,
    output logic        tx_ovalid,
    output logic [7:0]  tx_dout
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [4:0] LAST_BYTE = 5'd27;

    logic [1:0]       state;
    logic [4:0]       idx;
    logic [TMR_W-1:0] timer;
    logic [TRY_W-1:0] tries;
    logic [31:0]      tgt_ip;
    logic [223:0]     frame;

    logic match;
    logic accept;
    logic byte_xfer;
    logic timeout;
    logic last_try;
    logic cache_hit;
    logic [47:0] hit_mac;

    // Request handshake: a request transfers on a cycle where req_valid && req_ready.
    // Payload bytes transfer on a cycle where tx_ovalid && tx_send_next.
    assign accept    = req_valid && req_ready;
    assign byte_xfer = (state == S_SEND) && tx_send_next;
    assign match     = rx_done && (rx_oper == 16'h0002) && (rx_spa == tgt_ip) &&
                       (rx_tpa == IP_ADDR) && ((state == S_SEND) || (state == S_WAIT));
    assign timeout   = (state == S_WAIT) && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign last_try  = (tries == TRY_W'(MAX_TRIES));

    // ARP request payload, byte 0 in the top octet.
    assign frame = {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001,
                    MAC_ADDR, IP_ADDR, 48'h0, tgt_ip};

`ifdef ARP_CACHE_EN
    logic        cache_valid;
    logic [31:0] cache_ip;
    logic [47:0] cache_mac;

    assign cache_hit = cache_valid && (cache_ip == req_ip);
    assign hit_mac   = cache_mac;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_valid <= 1'b0;
            cache_ip    <= 32'h0;
            cache_mac   <= 48'h0;
        end else if (match) begin
            cache_valid <= 1'b1;
            cache_ip    <= tgt_ip;
            cache_mac   <= rx_sha;
        end else if (timeout && last_try && (cache_ip == tgt_ip)) begin
            cache_valid <= 1'b0;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_mac   = 48'h0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= 5'd0;
            timer     <= '0;
            tries     <= '0;
            tgt_ip    <= 32'h0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            res_mac   <= 48'h0;
        end else begin
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        tgt_ip <= req_ip;
                        if (cache_hit) begin
                            res_valid <= 1'b1;
                            res_mac   <= hit_mac;
                        end else begin
                            state <= S_SEND;
                            tries <= TRY_W'(1);
                            idx   <= 5'd0;
                        end
                    end
                end
                S_SEND: begin
                    if (match) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b1;
                        res_mac   <= rx_sha;
                    end else if (byte_xfer) begin
                        if (idx == LAST_BYTE) begin
                            state <= S_WAIT;
                            timer <= '0;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                S_WAIT: begin
                    // A reply arriving on the expiry cycle still wins.
                    if (match) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b1;
                        res_mac   <= rx_sha;
                    end else if (timeout) begin
                        if (last_try) begin
                            state     <= S_IDLE;
                            res_valid <= 1'b1;
                            res_err   <= 1'b1;
                        end else begin
                            state <= S_SEND;
                            tries <= tries + TRY_W'(1);
                            idx   <= 5'd0;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Held off during the result pulse so a new request starts the cycle after it.
    assign req_ready    = (state == S_IDLE) && !res_valid;
    assign tx_en        = (state == S_SEND);
    assign tx_ovalid    = (state == S_SEND);
    assign tx_dest      = 48'hFFFFFFFFFFFF;
    assign tx_ethertype = 16'h0806;

    always_comb begin
        tx_dout = 8'h00;
        if (state == S_SEND) begin
            tx_dout = frame[{LAST_BYTE - idx, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_arp_resolve.sv
// Self-checking bench for arp_resolve: directed sequence with randomized addresses and flow control.
module tb_arp_resolve;

    localparam int          TMO   = 16;
    localparam int          TRIES = 3;
    localparam logic [47:0] LMAC  = 48'hDEADBEEFCAFE;
    localparam logic [31:0] LIP   = 32'h69696969;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_ip;
    logic        req_ready;
    logic        res_valid;
    logic [47:0] res_mac;
    logic        res_err;
    logic        rx_done;
    logic [15:0] rx_oper;
    logic [47:0] rx_sha;
    logic [31:0] rx_spa;
    logic [31:0] rx_tpa;
    logic        tx_en;
    logic [47:0] tx_dest;
    logic [15:0] tx_ethertype;
    logic        tx_send_next;
    logic        tx_ovalid;
    logic [7:0]  tx_dout;

    arp_resolve #(
        .MAC_ADDR(LMAC), .IP_ADDR(LIP), .TIMEOUT_CYCLES(TMO), .MAX_TRIES(TRIES)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ip(req_ip), .req_ready(req_ready),
        .res_valid(res_valid), .res_mac(res_mac), .res_err(res_err),
        .rx_done(rx_done), .rx_oper(rx_oper), .rx_sha(rx_sha), .rx_spa(rx_spa), .rx_tpa(rx_tpa),
        .tx_en(tx_en), .tx_dest(tx_dest), .tx_ethertype(tx_ethertype),
        .tx_send_next(tx_send_next), .tx_ovalid(tx_ovalid), .tx_dout(tx_dout)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int start_q[$];
    int end_q[$];
    int res_cyc_q[$];
    logic [48:0] res_q[$];
    logic prev_en = 1'b0;

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (tx_ovalid && tx_send_next) got_q.push_back(tx_dout);
        if (tx_en && !prev_en) start_q.push_back(cyc);
        if (!tx_en && prev_en) end_q.push_back(cyc - 1);
        if (res_valid) begin
            res_q.push_back({res_err, res_mac});
            res_cyc_q.push_back(cyc);
        end
        prev_en = tx_en;
    end

    // 0: always ready, 1: random, 2: toggling
    int sn_mode = 0;
    initial begin
        tx_send_next = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (sn_mode)
                1:       tx_send_next = 1'($urandom_range(0, 1));
                2:       tx_send_next = ~tx_send_next;
                default: tx_send_next = 1'b1;
            endcase
        end
    end

    // ---------------- checker / driver tasks ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        start_q.delete();
        end_q.delete();
        res_q.delete();
        res_cyc_q.delete();
    endtask

    task automatic issue(input logic [31:0] ip);
        chk("req_ready before accept", 64'(req_ready), 64'h1);
        req_valid = 1'b1;
        req_ip    = ip;
        tick();
        req_valid = 1'b0;
        req_ip    = $urandom();
    endtask

    task automatic wait_en(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (tx_en !== lvl && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(tx_en), 64'(lvl));
    endtask

    task automatic reply(input logic [15:0] oper, input logic [47:0] sha,
                         input logic [31:0] spa, input logic [31:0] tpa);
        rx_done = 1'b1;
        rx_oper = oper;
        rx_sha  = sha;
        rx_spa  = spa;
        rx_tpa  = tpa;
        tick();
        rx_done = 1'b0;
        rx_sha  = $urandom();
    endtask

    // Reference payload from the ARP request layout.
    task automatic build_exp(input logic [31:0] ip);
        logic [7:0] hdr[8] = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
        foreach (hdr[i]) exp_q.push_back(hdr[i]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(8'(LMAC >> (8 * i)));
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'(LIP >> (8 * i)));
        repeat (6) exp_q.push_back(8'h00);
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'(ip >> (8 * i)));
    endtask

    task automatic check_frames(input string tag);
        chk({tag, " length"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({tag, " byte"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_ok(input string tag, input logic [47:0] mac);
        chk({tag, " res_valid"}, 64'(res_valid), 64'h1);
        chk({tag, " res_err"}, 64'(res_err), 64'h0);
        chk({tag, " res_mac"}, 64'(res_mac), 64'(mac));
    endtask

    function automatic logic [47:0] rand_mac();
        logic [47:0] m;
        m[47:32] = 16'($urandom());
        m[31:0]  = $urandom();
        return m;
    endfunction

    // ---------------- directed sequence ----------------
    logic [31:0] ip;
    logic [47:0] sha;
    logic [47:0] last_mac;
    int n;

    initial begin
        rst = 1'b0;
        req_valid = 1'b0;
        req_ip = 32'h0;
        rx_done = 1'b0;
        rx_oper = 16'h0;
        rx_sha = 48'h0;
        rx_spa = 32'h0;
        rx_tpa = 32'h0;
        repeat (3) tick();

        chk("reset req_ready", 64'(req_ready), 64'h1);
        chk("reset res_valid", 64'(res_valid), 64'h0);
        chk("reset res_err", 64'(res_err), 64'h0);
        chk("reset res_mac", 64'(res_mac), 64'h0);
        chk("reset tx_en", 64'(tx_en), 64'h0);
        chk("reset tx_ovalid", 64'(tx_ovalid), 64'h0);
        chk("reset tx_dout", 64'(tx_dout), 64'h0);
        chk("tx_dest", 64'(tx_dest), 64'hFFFFFFFFFFFF);
        chk("tx_ethertype", 64'(tx_ethertype), 64'h0806);
        rst = 1'b1;
        tick();
        clear_mon();

        // Basic request, continuous flow control
        issue(32'hC0A80001);
        chk("first tx_ovalid latency", 64'(tx_ovalid), 64'h1);
        chk("tx_en in send", 64'(tx_en), 64'h1);
        chk("req_ready busy", 64'(req_ready), 64'h0);
        wait_en(1'b0, 200, "frame1 end");
        build_exp(32'hC0A80001);
        check_frames("frame1");

        // Matching reply
        reply(16'h0002, 48'h112233445566, 32'hC0A80001, LIP);
        check_ok("reply1", 48'h112233445566);
        last_mac = 48'h112233445566;
        tick();
        chk("reply1 req_ready after", 64'(req_ready), 64'h1);
        chk("reply1 res_valid pulse", 64'(res_valid), 64'h0);
        clear_mon();

`ifdef ARP_CACHE_EN
        issue(32'hC0A80001);
        check_ok("cache hit", 48'h112233445566);
        chk("cache hit no tx", 64'(tx_en), 64'h0);
        repeat (5) tick();
        chk("cache hit no bytes", 64'(got_q.size()), 64'h0);
        clear_mon();
`else
        issue(32'hC0A80001);
        chk("repeat ip transmits", 64'(tx_ovalid), 64'h1);
        wait_en(1'b0, 200, "repeat frame end");
        build_exp(32'hC0A80001);
        check_frames("repeat frame");
        reply(16'h0002, 48'h112233445566, 32'hC0A80001, LIP);
        check_ok("repeat reply", 48'h112233445566);
        tick();
        clear_mon();
`endif

        // Random flow control, then toggling flow control
        for (int t = 0; t < 4; t++) begin
            sn_mode = (t == 3) ? 2 : 1;
            ip  = $urandom();
            sha = rand_mac();
            issue(ip);
            wait_en(1'b0, 400, "rand frame end");
            build_exp(ip);
            check_frames("rand frame");
            reply(16'h0002, sha, ip, LIP);
            check_ok("rand reply", sha);
            last_mac = sha;
            tick();
            clear_mon();
        end
        sn_mode = 0;

        // Non-matching replies are ignored; retry follows
        ip  = $urandom();
        sha = rand_mac();
        issue(ip);
        wait_en(1'b0, 200, "bad-reply frame end");
        build_exp(ip);
        check_frames("bad-reply frame");
        reply(16'h0001, sha, ip, LIP);
        chk("oper=1 ignored", 64'(res_valid), 64'h0);
        reply(16'h0002, sha, ip ^ 32'h1, LIP);
        chk("spa mismatch ignored", 64'(res_valid), 64'h0);
        reply(16'h0002, sha, ip, LIP ^ 32'h100);
        chk("tpa mismatch ignored", 64'(res_valid), 64'h0);
        wait_en(1'b1, 40, "retry frame start");
        wait_en(1'b0, 200, "retry frame end");
        build_exp(ip);
        check_frames("retry frame");
        reply(16'h0002, sha, ip, LIP);
        check_ok("retry reply", sha);
        last_mac = sha;
        tick();
        clear_mon();

        // Match during SEND aborts the frame
        ip  = $urandom();
        sha = rand_mac();
        issue(ip);
        repeat (5) tick();
        reply(16'h0002, sha, ip, LIP);
        check_ok("mid-send reply", sha);
        chk("mid-send tx_en dropped", 64'(tx_en), 64'h0);
        last_mac = sha;
        tick();
        clear_mon();

        // No reply: all tries time out
        ip = $urandom();
        issue(ip);
        n = 0;
        while (res_valid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("timeout res_valid", 64'(res_valid), 64'h1);
        chk("timeout res_err", 64'(res_err), 64'h1);
        chk("timeout res_mac kept", 64'(res_mac), 64'(last_mac));
        tick();
        chk("timeout frame count", 64'(start_q.size()), 64'(TRIES));
        chk("timeout end count", 64'(end_q.size()), 64'(TRIES));
        chk("timeout result count", 64'(res_q.size()), 64'h1);
        if (start_q.size() == TRIES && end_q.size() == TRIES && res_cyc_q.size() == 1) begin
            for (int k = 0; k < TRIES; k++) begin
                chk("frame duration", 64'(end_q[k] - start_q[k] + 1), 64'd28);
                if (k > 0) chk("frame gap", 64'(start_q[k] - end_q[k-1] - 1), 64'(TMO));
            end
            chk("final gap", 64'(res_cyc_q[0] - end_q[TRIES-1] - 1), 64'(TMO));
        end
        for (int k = 0; k < TRIES; k++) build_exp(ip);
        check_frames("timeout frames");
        clear_mon();

        // Reset in the middle of a frame
        ip = $urandom();
        issue(ip);
        n = 0;
        while (got_q.size() < 10 && n < 100) begin
            tick();
            n++;
        end
        chk("bytes before reset", 64'(got_q.size()), 64'd10);
        rst = 1'b0;
        #1;
        chk("mid-reset tx_ovalid", 64'(tx_ovalid), 64'h0);
        chk("mid-reset tx_en", 64'(tx_en), 64'h0);
        chk("mid-reset req_ready", 64'(req_ready), 64'h1);
        chk("mid-reset tx_dout", 64'(tx_dout), 64'h0);
        chk("mid-reset res_mac", 64'(res_mac), 64'h0);
        tick();
        rst = 1'b1;
        tick();
        clear_mon();
        ip = $urandom();
        issue(ip);
        chk("post-reset tx_ovalid", 64'(tx_ovalid), 64'h1);
        wait_en(1'b0, 200, "post-reset frame end");
        build_exp(ip);
        check_frames("post-reset frame");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
